// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying result, destination index and flags.
// SKID=1 gives a two-entry skid buffer with a registered in_ready; SKID=0 is a single entry.
module pipe_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 5,
   parameter int FLAGS_W = 16,
   parameter int SKID    = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [RD_W-1:0]    in_rd,
   input  logic [FLAGS_W-1:0] in_flags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [RD_W-1:0]    out_rd,
   output logic [FLAGS_W-1:0] out_flags,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);
   localparam int PW = DATA_W + RD_W + FLAGS_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2} state_t;

   logic [PW-1:0]    in_word;
   logic [PW-1:0]    head_word;
   logic             head_valid;
   logic [CNT_W-1:0] stall_reg;

   assign in_word                       = {in_data, in_rd, in_flags};
   assign {out_data, out_rd, out_flags} = head_word;
   assign out_valid                     = head_valid;
   assign stall_cnt                     = stall_reg;

   generate
      if (SKID != 0) begin : g_skid
         state_t        state_reg, state_next;
         logic [PW-1:0] main_reg, main_next;
         logic [PW-1:0] skid_reg, skid_next;
         logic          ready_reg;
         logic          in_xfer, out_xfer;

         assign in_xfer  = in_valid && ready_reg;
         assign out_xfer = (state_reg != EMPTY) && out_ready;

         always_comb begin
            state_next = state_reg;
            main_next  = main_reg;
            skid_next  = skid_reg;
            if (flush) begin
               state_next = EMPTY;
               main_next  = '0;
               skid_next  = '0;
            end else begin
               case (state_reg)
                  EMPTY: if (in_xfer) begin
                     state_next = MAIN;
                     main_next  = in_word;
                  end
                  MAIN: begin
                     if (in_xfer && out_xfer) begin
                        main_next = in_word;
                     end else if (out_xfer) begin
                        // main keeps its last value so payload outputs hold while idle
                        state_next = EMPTY;
                     end else if (in_xfer) begin
                        state_next = FULL;
                        skid_next  = in_word;
                     end
                  end
                  FULL: if (out_xfer) begin
                     state_next = MAIN;
                     main_next  = skid_reg;
                  end
                  default: state_next = EMPTY;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state_reg <= EMPTY;
               main_reg  <= '0;
               skid_reg  <= '0;
               ready_reg <= 1'b1;
            end else begin
               state_reg <= state_next;
               main_reg  <= main_next;
               skid_reg  <= skid_next;
               ready_reg <= (state_next != FULL);
            end
         end

         assign in_ready   = ready_reg;
         assign head_valid = (state_reg != EMPTY);
         assign head_word  = main_reg;
         assign occupancy  = state_reg;
      end else begin : g_single
         logic          valid_reg, valid_next;
         logic [PW-1:0] main_reg, main_next;
         logic          ready_c, in_xfer;

         // A leaving entry frees the slot in the same cycle.
         assign ready_c = !valid_reg || out_ready;
         assign in_xfer = in_valid && ready_c;

         always_comb begin
            valid_next = valid_reg;
            main_next  = main_reg;
            if (flush) begin
               valid_next = 1'b0;
               main_next  = '0;
            end else if (in_xfer) begin
               valid_next = 1'b1;
               main_next  = in_word;
            end else if (valid_reg && out_ready) begin
               valid_next = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               main_reg  <= '0;
            end else begin
               valid_reg <= valid_next;
               main_reg  <= main_next;
            end
         end

         assign in_ready   = ready_c;
         assign head_valid = valid_reg;
         assign head_word  = main_reg;
         assign occupancy  = {1'b0, valid_reg};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_reg <= '0;
      end else if (head_valid && !out_ready && (stall_reg != {CNT_W{1'b1}})) begin
         stall_reg <= stall_reg + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a table of SKID=1 vectors plus hand-written
// sequences for streaming, counter saturation and the single-entry variant.
module tb_pipe_stage_reg;
   logic        clk;
   logic        rst_n;
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [4:0]  in_rd, out_rd;
   logic [15:0] in_flags, out_flags;
   logic [1:0]  occupancy;
   logic [3:0]  stall_cnt;

   logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
   logic [31:0] s0_in_data, s0_out_data;
   logic [4:0]  s0_in_rd, s0_out_rd;
   logic [15:0] s0_in_flags, s0_out_flags;
   logic [1:0]  s0_occupancy;
   logic [15:0] s0_stall_cnt;

   int errors = 0;
   int checks = 0;

   pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rd(in_rd), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_flags(out_flags),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.SKID(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(s0_flush),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready),
      .in_data(s0_in_data), .in_rd(s0_in_rd), .in_flags(s0_in_flags),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready),
      .out_data(s0_out_data), .out_rd(s0_out_rd), .out_flags(s0_out_flags),
      .occupancy(s0_occupancy), .stall_cnt(s0_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, flush, in_valid;
      logic [31:0] in_data;
      logic [4:0]  in_rd;
      logic [15:0] in_flags;
      logic        out_ready;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic [15:0] exp_flags;
      logic [1:0]  exp_occ;
      logic        exp_ready;
      logic [3:0]  exp_stall;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] d,
                               input logic [4:0] rd, input logic [15:0] fg, input logic ordy,
                               input logic ev, input logic [31:0] ed, input logic [4:0] erd,
                               input logic [15:0] efg, input logic [1:0] eocc, input logic erdy,
                               input logic [3:0] est);
      vec_t v;
      v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.in_rd = rd;
      v.in_flags = fg; v.out_ready = ordy; v.exp_valid = ev; v.exp_data = ed;
      v.exp_rd = erd; v.exp_flags = efg; v.exp_occ = eocc; v.exp_ready = erdy;
      v.exp_stall = est;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic f, input logic iv, input logic [31:0] d,
                        input logic [4:0] rd, input logic [15:0] fg, input logic ordy);
      flush = f; in_valid = iv; in_data = d; in_rd = rd; in_flags = fg; out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      s0_flush = 0; s0_in_valid = 0; s0_in_data = 0; s0_in_rd = 0; s0_in_flags = 0; s0_out_ready = 0;

      // reset, single transfer, back-pressure fill/drain, flush while full and while empty
      vecs[0]  = mk(0,0,0,32'h0,0,16'h0,0,        0,32'h0,0,16'h0,0,1,0);
      vecs[1]  = mk(0,0,0,32'h0,0,16'h0,0,        0,32'h0,0,16'h0,0,1,0);
      vecs[2]  = mk(1,0,1,32'hDEADBEEF,7,16'h0011,1, 1,32'hDEADBEEF,7,16'h0011,1,1,0);
      vecs[3]  = mk(1,0,0,32'h0,0,16'h0,1,        0,32'hDEADBEEF,7,16'h0011,0,1,0);
      vecs[4]  = mk(1,0,1,32'h1,1,16'h1,0,        1,32'h1,1,16'h1,1,1,0);
      vecs[5]  = mk(1,0,1,32'h2,2,16'h2,0,        1,32'h1,1,16'h1,2,0,1);
      vecs[6]  = mk(1,0,1,32'h3,3,16'h3,0,        1,32'h1,1,16'h1,2,0,2);
      vecs[7]  = mk(1,0,1,32'h3,3,16'h3,1,        1,32'h2,2,16'h2,1,1,2);
      vecs[8]  = mk(1,0,1,32'h3,3,16'h3,1,        1,32'h3,3,16'h3,1,1,2);
      vecs[9]  = mk(1,0,0,32'h0,0,16'h0,1,        0,32'h3,3,16'h3,0,1,2);
      vecs[10] = mk(1,0,1,32'h10,5'h10,16'h10,0,  1,32'h10,5'h10,16'h10,1,1,2);
      vecs[11] = mk(1,0,1,32'h11,5'h11,16'h11,0,  1,32'h10,5'h10,16'h10,2,0,3);
      vecs[12] = mk(1,1,1,32'hAA,5'h0A,16'hAA,0,  0,32'h0,0,16'h0,0,1,4);
      vecs[13] = mk(1,0,0,32'h0,0,16'h0,1,        0,32'h0,0,16'h0,0,1,4);
      vecs[14] = mk(1,1,1,32'hAA,5'h0A,16'hAA,1,  0,32'h0,0,16'h0,0,1,4);
      vecs[15] = mk(1,0,0,32'h0,0,16'h0,1,        0,32'h0,0,16'h0,0,1,4);

      for (int i = 0; i < 16; i++) begin
         rst_n = vecs[i].rst_n;
         drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].in_rd,
               vecs[i].in_flags, vecs[i].out_ready);
         step();
         $display("vec %0d: out_valid=%0b out_data=%h occ=%0d in_ready=%0b stall=%0d",
                  i, out_valid, out_data, occupancy, in_ready, stall_cnt);
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
         check($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(vecs[i].exp_rd));
         check($sformatf("vec%0d out_flags", i), 32'(out_flags), 32'(vecs[i].exp_flags));
         check($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
      end

      // streaming after a fresh reset
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("stream reset stall_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         drive(0, 1, 32'(1000 + k), 5'(k), 16'(k), 1);
         step();
         check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("stream%0d out_data", k), out_data, 32'(1000 + k));
         check($sformatf("stream%0d occupancy", k), 32'(occupancy), 32'd1);
      end
      $display("stream: 100 transfers, last out_data=%h stall=%0d", out_data, stall_cnt);
      check("stream stall_cnt", 32'(stall_cnt), 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      step();
      check("stream drain occupancy", 32'(occupancy), 32'd0);

      // stall counter saturation at 15 with CNT_W=4
      drive(0, 1, 32'h5, 5'd5, 16'h5, 0);
      step();
      check("sat load out_valid", 32'(out_valid), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         $display("sat cycle %0d: stall=%0d", i, stall_cnt);
         check($sformatf("sat%0d stall_cnt", i), 32'(stall_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      end
      rst_n = 1'b0;
      step();
      check("sat reset stall_cnt", 32'(stall_cnt), 32'd0);
      check("sat reset out_valid", 32'(out_valid), 32'd0);
      check("sat reset occupancy", 32'(occupancy), 32'd0);
      check("sat reset out_data", out_data, 32'd0);
      check("sat reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      // SKID=0: out_ready 1,0,1 with in_valid held; in_ready checked before each edge
      s0_in_valid = 1; s0_in_data = 32'h21; s0_in_rd = 5'd1; s0_in_flags = 16'h21; s0_out_ready = 1;
      #1;
      check("s0 a in_ready", 32'(s0_in_ready), 32'd1);
      step();
      $display("s0 a: out_valid=%0b out_data=%h", s0_out_valid, s0_out_data);
      check("s0 a out_valid", 32'(s0_out_valid), 32'd1);
      check("s0 a out_data", s0_out_data, 32'h21);
      check("s0 a occupancy", 32'(s0_occupancy), 32'd1);

      s0_in_data = 32'h22; s0_in_rd = 5'd2; s0_in_flags = 16'h22; s0_out_ready = 0;
      #1;
      check("s0 b in_ready", 32'(s0_in_ready), 32'd0);
      step();
      $display("s0 b: out_valid=%0b out_data=%h", s0_out_valid, s0_out_data);
      check("s0 b out_data", s0_out_data, 32'h21);
      check("s0 b occupancy", 32'(s0_occupancy), 32'd1);

      s0_out_ready = 1;
      #1;
      check("s0 c in_ready", 32'(s0_in_ready), 32'd1);
      step();
      $display("s0 c: out_valid=%0b out_data=%h", s0_out_valid, s0_out_data);
      check("s0 c out_valid", 32'(s0_out_valid), 32'd1);
      check("s0 c out_data", s0_out_data, 32'h22);
      check("s0 c out_rd", 32'(s0_out_rd), 32'd2);

      s0_in_valid = 0;
      #1;
      check("s0 d in_ready", 32'(s0_in_ready), 32'd1);
      step();
      $display("s0 d: out_valid=%0b occ=%0d stall=%0d", s0_out_valid, s0_occupancy, s0_stall_cnt);
      check("s0 d out_valid", 32'(s0_out_valid), 32'd0);
      check("s0 d occupancy", 32'(s0_occupancy), 32'd0);
      check("s0 d stall_cnt", 32'(s0_stall_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed enable/flush latches between pipeline stages. It carries a result word, a destination-register index and an instruction-flag vector. Transfers use a valid/ready handshake, with an optional 2-entry skid buffer that gives a fully registered in_ready. It also provides a synchronous flush and a saturating back-pressure stall counter for performance monitoring. Instances sit between any two stages, for example execute to memory.

Parameters:
DATA_W, 32, width of result payload
RD_W, 5, width of destination-register index
FLAGS_W, 16, width of instruction-flag vector
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream presents a payload
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  result payload
in_rd  in  RD_W  destination-register index
in_flags  in  FLAGS_W  instruction flags
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head entry
out_data  out  DATA_W  head result
out_rd  out  RD_W  head destination index
out_flags  out  FLAGS_W  head flags
occupancy  out  2  number of held entries (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: clk edge with rst_n=0 forces out_valid=0, occupancy=0, out_data/out_rd/out_flags=0 and stall_cnt=0. When SKID=1, in_ready=1 on the first cycle after reset. Reset overrides flush and all handshakes.
- Handshake: an input transfer occurs when in_valid&&in_ready. An output transfer occurs when out_valid&&out_ready. Payload is sampled only on an input transfer.
- Latency: when the stage is empty, an accepted payload appears on out_* with out_valid=1 on the next cycle. There is no combinational path from in_* to out_*.
- SKID=1 states:
  - EMPTY: in_ready=1, out_valid=0.
  - MAIN: in_ready=1, out_valid=1.
  - FULL: main and skid both held; in_ready=0.
- SKID=1 transitions:
  - EMPTY→MAIN on an input transfer.
  - MAIN stays MAIN on simultaneous input and output transfers; the new payload goes into main.
  - MAIN→EMPTY on an output transfer with no input transfer.
  - MAIN→FULL on an input transfer with no output transfer; the new payload goes into skid.
  - FULL→MAIN on an output transfer; skid moves to main.
- SKID=1 in_ready is a register equal to NOT(next state is FULL).
- SKID=0: single entry. in_ready = !out_valid || out_ready (combinational), so a new payload may be loaded in the same cycle the old one leaves.
- Ordering: strict FIFO order. No payload is dropped or duplicated except by flush.
- Flush (rst_n=1, flush=1):
  - next cycle out_valid=0, occupancy=0 and all payload outputs are zero.
  - any input presented in the same cycle is discarded, even if in_ready=1.
  - an output transfer in the flush cycle still counts as completed downstream.
  - SKID=1 in_ready=1 on the following cycle.
  - stall_cnt is not affected.
- When out_valid=0 outside flush and reset, payload outputs hold their last value. Consumers must qualify with out_valid.
- stall_cnt:
  - increments by 1 each cycle with out_valid=1 and out_ready=0.
  - holds at 2^CNT_W-1; no wrap.
  - cleared only by reset.
- occupancy is registered and always consistent with the state above.

Test Plan:
- Reset, then a single transfer: rst_n=0 for 2 cycles, then in_data=0xDEADBEEF, in_rd=5'd7, in_flags=16'h0011 with in_valid=1 for 1 cycle and out_ready=1. Required: out_valid=1 with those values exactly 1 cycle later, occupancy=1, then 0 on the next cycle.
- Back-pressure fill (SKID=1): out_ready=0, push 0x1, 0x2, 0x3 on consecutive cycles. Required: 0x1 and 0x2 accepted, in_ready=0 while occupancy=2, 0x3 held upstream. Then out_ready=1 yields 0x1, 0x2, 0x3 in order, and stall_cnt equals the number of blocked cycles.
- Streaming: in_valid=1 and out_ready=1 continuously for 100 cycles with incrementing data. Required: one output per cycle, occupancy stays 1, stall_cnt=0.
- Flush while full: occupancy=2, then flush=1 with in_valid=1 and in_data=0xAA. Required: next cycle out_valid=0, out_data=0, out_rd=0, out_flags=0, occupancy=0, in_ready=1; 0xAA never appears on the output.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt reaches 15 and stays at 15. A later rst_n=0 clears it to 0.
- SKID=0 variant: out_ready toggles 1,0,1 with in_valid=1. Required: in_ready follows !out_valid||out_ready in the same cycle, and no data is lost or duplicated.
